// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Gives one of four 64-bit arithmetic units (0=add, 1=sub, 2=mul, 3=div)
// exclusive ownership of the shared execution/result path. Grants go
// round-robin and are held until the owner signals completion. The owner's
// result is then latched onto a shared registered bus with a one-cycle ack.
// A watchdog reclaims the grant from a unit that never completes.
//
// Ports
//   clk             clock, all state updates on rising edge
//   rst_n           synchronous reset, active low
//   req_i[3:0]      per-unit request, held until ack or abandonment
//   done_i[3:0]     per-unit completion strobe, only the owner's bit is used
//   res_in_i        unit results, unit i on bits [i*W +: W]
//   grant_o[3:0]    one-hot ownership, registered
//   working_o       high whenever any grant bit is high
//   owner_o[1:0]    index of current or most recent owner
//   ack_o[3:0]      one-cycle completion pulse to the owner
//   result_o        result of the last completed operation
//   result_valid_o  one-cycle pulse coincident with ack_o
//   timeout_err_o   one-cycle pulse when the watchdog reclaims a grant
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int unsigned W       = 64,
  parameter int unsigned TIMEOUT = 255   // legal range 1..65535
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req_i,
  input  logic [3:0]     done_i,
  input  logic [4*W-1:0] res_in_i,
  output logic [3:0]     grant_o,
  output logic           working_o,
  output logic [1:0]     owner_o,
  output logic [3:0]     ack_o,
  output logic [W-1:0]   result_o,
  output logic           result_valid_o,
  output logic           timeout_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Last count value still allowed; reaching it in BUSY forces the reclaim,
  // so the grant is high for exactly TIMEOUT cycles.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e         state_q;
  logic [1:0]     ptr_q;
  logic [15:0]    cnt_q;
  logic [3:0]     grant_q;
  logic           working_q;
  logic [1:0]     owner_q;
  logic [3:0]     ack_q;
  logic [W-1:0]   result_q;
  logic           result_valid_q;
  logic           timeout_err_q;

  logic [1:0]     winner_d;
  logic [1:0]     cand;

  // Round-robin pick: scan ptr, ptr+1, ... (mod 4). Walking the offsets from
  // far to near lets the nearest requester overwrite the others.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    winner_d = ptr_q;
    cand     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req_i[cand]) winner_d = cand;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      grant_q        <= '0;
      working_q      <= 1'b0;
      owner_q        <= '0;
      ack_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      // Pulse outputs are high for one cycle only unless re-asserted below.
      ack_q          <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q   <= BUSY;
            grant_q   <= 4'b0001 << winner_d;
            working_q <= 1'b1;
            owner_q   <= winner_d;
            cnt_q     <= '0;
          end
        end

        BUSY: begin
          if (!req_i[owner_q]) begin
            // Owner withdrew: release silently, result untouched.
            state_q   <= IDLE;
            grant_q   <= '0;
            working_q <= 1'b0;
            ptr_q     <= owner_q + 2'd1;
          end else if (done_i[owner_q]) begin
            state_q   <= DONE;
            grant_q   <= '0;
            working_q <= 1'b0;
            result_q  <= res_in_i[owner_q*W +: W];
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            working_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            ptr_q         <= owner_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        DONE: begin
          // Pointer moves past the owner so a unit that keeps requesting
          // only wins again when nobody else is asking.
          state_q        <= IDLE;
          ack_q          <= 4'b0001 << owner_q;
          result_valid_q <= 1'b1;
          ptr_q          <= owner_q + 2'd1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign working_o      = working_q;
  assign owner_o        = owner_q;
  assign ack_o          = ack_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign timeout_err_o  = timeout_err_q;

endmodule
